// File: rtl/mem_pkg.sv
// Shared types and request-legality helpers for the data-memory responder.
// Mode codes follow the RV32 load/store funct3 encoding.
package mem_pkg;

  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101
  } acc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RESP    = 2'd2
  } dmem_state_e;

  // Unsigned modes only make sense for loads.
  function automatic logic mode_legal(input logic [2:0] mode, input logic wr);
    logic ok;
    case (acc_mode_e'(mode))
      MODE_B, MODE_H, MODE_W: ok = 1'b1;
      MODE_BU, MODE_HU:       ok = !wr;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] mode, input logic [1:0] lane);
    logic bad;
    case (acc_mode_e'(mode))
      MODE_H, MODE_HU: bad = lane[0];
      MODE_W:          bad = (lane != 2'b00);
      default:         bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store strobes/replication and load extraction/extension.
// Purely combinational; the top decides when each side is meaningful.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  st_mode,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_word,
  input  logic [2:0]  ld_mode,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    st_strb = 4'hF;
    st_word = st_data;
    case (st_mode[1:0])
      2'b00: begin
        st_strb = 4'b0001 << st_lane;
        st_word = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_strb = 4'b0011 << st_lane;
        st_word = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v  = ld_word[{ld_lane, 3'b000} +: 8];
    half_v  = ld_lane[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = '0;
    case (acc_mode_e'(ld_mode))
      MODE_B:  ld_data = {{24{byte_v[7]}}, byte_v};
      MODE_H:  ld_data = {{16{half_v[15]}}, half_v};
      MODE_W:  ld_data = ld_word;
      MODE_BU: ld_data = {24'h0, byte_v};
      MODE_HU: ld_data = {16'h0, half_v};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one request at a time, word-wide synchronous SRAM,
// one response per request with an error flag.
module dmem_resp
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // a response transfers on a rising edge where rsp_valid & rsp_ready, and is
  // held unchanged until then.

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  dmem_state_e state;
  logic [31:0] off;
  logic        in_range, req_err, accept;
  logic [AW-1:0] widx;
  logic [2:0]  rd_mode;
  logic [1:0]  rd_lane;
  logic [31:0] rd_word, ld_data, st_word;
  logic [3:0]  st_strb;
  logic [31:0] mem [DEPTH_WORDS];

  assign off       = req_addr - BASE_ADDR;
  assign in_range  = {1'b0, off} < LIMIT;
  assign widx      = off[AW+1:2];
  assign req_ready = (state == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;
  assign req_err   = (req_rd == req_wr) || !mode_legal(req_mode, req_wr) ||
                     is_misaligned(req_mode, req_addr[1:0]) || !in_range;

  mem_lane_align u_align (
    .st_mode (req_mode),
    .st_lane (req_addr[1:0]),
    .st_data (req_wdata),
    .st_strb (st_strb),
    .st_word (st_word),
    .ld_mode (rd_mode),
    .ld_lane (rd_lane),
    .ld_word (rd_word),
    .ld_data (ld_data)
  );

  // SRAM array: contents survive reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (accept && !req_err) begin
      if (req_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (st_strb[i]) mem[widx][8*i +: 8] <= st_word[8*i +: 8];
        end
      end else begin
        rd_word <= mem[widx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_mode   <= 3'b010;
      rd_lane   <= 2'b00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_err || req_wr) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= req_err;
              rsp_rdata <= '0;
            end else begin
              state   <= ST_RD_WAIT;
              rd_mode <= req_mode;
              rd_lane <= req_addr[1:0];
            end
          end
        end
        ST_RD_WAIT: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= ld_data;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios then randomized traffic
// against a byte-addressed reference model of the memory.
module tb_dmem_resp;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [2:0]  M_B = 3'b000, M_H = 3'b001, M_W = 3'b010;
  localparam logic [2:0]  M_BU = 3'b100, M_HU = 3'b101;

  logic        clk, rst;
  logic        req_valid, req_ready, req_rd, req_wr;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_mode;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [1:0]  dbg_state;

  dmem_resp #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_mode(req_mode),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  logic [7:0]  model_mem [bit [31:0]];
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // reference model
  function automatic logic model_err(input logic rd, input logic wr,
                                     input logic [31:0] addr, input logic [2:0] mode);
    logic [31:0] off;
    off = addr - BASE;
    if (rd == wr) return 1'b1;
    if (mode == 3'd3 || mode == 3'd6 || mode == 3'd7) return 1'b1;
    if (wr && mode[2]) return 1'b1;
    if ((mode == M_H || mode == M_HU) && addr[0]) return 1'b1;
    if (mode == M_W && addr[1:0] != 2'b00) return 1'b1;
    return off >= 32'(DEPTH * 4);
  endfunction

  function automatic int size_of(input logic [2:0] mode);
    return (mode[1:0] == 2'b00) ? 1 : (mode[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] mode);
    int n;
    logic [31:0] v;
    n = size_of(mode);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(model_mem[addr + 32'(i)]) << (8 * i));
    if (n < 4 && !mode[2] && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [2:0] mode, input logic [31:0] wd);
    for (int i = 0; i < size_of(mode); i++) model_mem[addr + 32'(i)] = wd[8*i +: 8];
  endtask

  // driver: one full transaction, with response held for 'hold' cycles
  task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [2:0] mode, input logic [31:0] wd,
                      input int hold, input string tag);
    logic        e;
    logic [31:0] exp_d;
    int          exp_lat, lat, n;
    e       = model_err(rd, wr, addr, mode);
    exp_lat = (!e && rd) ? 2 : 1;
    exp_q.push_back((!e && rd) ? model_load(addr, mode) : 32'h0);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ":req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rd = rd; req_wr = wr;
    req_addr = addr; req_mode = mode; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rd = 1'($urandom); req_wr = 1'($urandom); req_addr = $urandom;
    req_mode = 3'($urandom); req_wdata = $urandom;
    if (!e && wr) model_store(addr, mode, wd);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    exp_d = exp_q.pop_front();
    chk({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":rdata"}, rsp_rdata, exp_d);
    chk({tag, ":err"}, 32'(rsp_err), 32'(e));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ":hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ":hold_rdata"}, rsp_rdata, exp_d);
      chk({tag, ":hold_err"}, 32'(rsp_err), 32'(e));
      chk({tag, ":hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk({tag, ":req_ready_after"}, 32'(req_ready), 32'd1);
    chk({tag, ":rsp_valid_after"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic rd, wr;
    logic [31:0] addr;
    rst = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
    req_addr = '0; req_mode = '0; req_wdata = '0; rsp_ready = 1'b0;

    // reset values
    #12;
    chk("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst:rsp_rdata", rsp_rdata, 32'd0);
    chk("rst:rsp_err", 32'(rsp_err), 32'd0);
    chk("rst:req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst:req_ready_release", 32'(req_ready), 32'd1);

    // word store/load round trip
    xact(1'b0, 1'b1, BASE + 32'h10, M_W, 32'hDEAD_BEEF, 0, "sw10");
    xact(1'b1, 1'b0, BASE + 32'h10, M_W, 32'h0, 0, "lw10");
    chk("lw10_const", model_load(BASE + 32'h10, M_W), 32'hDEAD_BEEF);

    // byte lanes and extension
    xact(1'b0, 1'b1, BASE + 32'h20, M_W, 32'h0, 0, "sw20");
    xact(1'b0, 1'b1, BASE + 32'h23, M_B, 32'h80, 0, "sb23");
    xact(1'b1, 1'b0, BASE + 32'h23, M_B, 32'h0, 0, "lb23");
    xact(1'b1, 1'b0, BASE + 32'h23, M_BU, 32'h0, 0, "lbu23");
    xact(1'b1, 1'b0, BASE + 32'h20, M_W, 32'h0, 0, "lw20");

    // halfwords and misalignment
    xact(1'b0, 1'b1, BASE + 32'h30, M_W, 32'h1234_5678, 0, "sw30");
    xact(1'b0, 1'b1, BASE + 32'h32, M_H, 32'hFFFF_8001, 0, "sh32");
    xact(1'b1, 1'b0, BASE + 32'h32, M_H, 32'h0, 0, "lh32");
    xact(1'b1, 1'b0, BASE + 32'h32, M_HU, 32'h0, 0, "lhu32");
    xact(1'b1, 1'b0, BASE + 32'h30, M_W, 32'h0, 0, "lw30");
    xact(1'b1, 1'b0, BASE + 32'h31, M_H, 32'h0, 0, "lh31_mis");
    xact(1'b0, 1'b1, BASE + 32'h22, M_W, 32'hFFFF_FFFF, 0, "sw22_mis");
    xact(1'b1, 1'b0, BASE + 32'h20, M_W, 32'h0, 0, "lw20_after");

    // illegal requests and range boundaries
    xact(1'b1, 1'b0, BASE + 32'(DEPTH * 4), M_W, 32'h0, 0, "lw_end");
    xact(1'b1, 1'b0, BASE + 32'(DEPTH * 4 - 4), M_W, 32'h0, 0, "lw_last");
    xact(1'b1, 1'b0, BASE - 32'd4, M_W, 32'h0, 0, "lw_below");
    xact(1'b1, 1'b1, BASE + 32'h10, M_W, 32'h0, 0, "rdwr_both");
    xact(1'b0, 1'b0, BASE + 32'h10, M_W, 32'h0, 0, "rdwr_none");
    xact(1'b1, 1'b0, BASE + 32'h10, 3'b011, 32'h0, 0, "mode011");
    xact(1'b0, 1'b1, BASE + 32'h10, M_BU, 32'h55, 0, "sbu_illegal");
    xact(1'b1, 1'b0, BASE + 32'h10, M_W, 32'h0, 0, "lw10_again");

    // backpressure
    xact(1'b1, 1'b0, BASE + 32'h10, M_W, 32'h0, 5, "lw10_hold");

    // reset with a store response pending: store stays committed, response dropped
    @(negedge clk);
    req_valid = 1'b1; req_rd = 1'b0; req_wr = 1'b1;
    req_addr = BASE + 32'h40; req_mode = M_W; req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_store(BASE + 32'h40, M_W, 32'hCAFE_F00D);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst:req_ready", 32'(req_ready), 32'd0);
    chk("midrst:rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst:req_ready_release", 32'(req_ready), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("midrst:no_rsp", 32'(rsp_valid), 32'd0);
    end
    xact(1'b1, 1'b0, BASE + 32'h40, M_W, 32'h0, 0, "lw40_after_rst");

    // reset with a load in flight
    @(negedge clk);
    req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0;
    req_addr = BASE + 32'h40; req_mode = M_W;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ldrst:req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ldrst:no_rsp", 32'(rsp_valid), 32'd0);
      chk("ldrst:req_ready", 32'(req_ready), 32'd1);
    end

    // fill every word, then randomized traffic
    for (int w = 0; w < DEPTH; w++) xact(1'b0, 1'b1, BASE + 32'(4 * w), M_W, $urandom, 0, "fill");
    for (int k = 0; k < 300; k++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 4) || (r == 8);
      wr = ((r >= 4) && (r < 8)) || (r == 8);
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = BASE + 32'($urandom_range(0, DEPTH * 4 + 7));
      xact(rd, wr, addr, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
